gen_dir_campo: RTL

//  Edit-cursor generator: encoder side of the field-address decoder. Turns debounced front-panel

---
 rtl/gen_dir_campo.sv | 82 ++++++++
 1 files changed

// File: rtl/gen_dir_campo.sv
// gen_dir_campo: turns debounced panel buttons into a field cursor, edit-group enables, blink and timeout
module gen_dir_campo #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int BLINK_HALF  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_hora,
  input  logic       sel_fecha,
  input  logic       sel_timer,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_salir,
  output logic [1:0] dir_bin,
  output logic       en_cont_hora,
  output logic       en_cont_fecha,
  output logic       en_cont_timer,
  output logic       parpadeo,
  output logic       editando
);
  typedef enum logic [1:0] {IDLE, ED_HORA, ED_FECHA, ED_TIMER} state_t;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  state_t           r_state, w_state_n;
  logic [2:0]       r_q, r_qq;
  logic [1:0]       r_cur, w_cur_n, w_cur_ok;
  logic [CNT_W-1:0] r_tmo, w_tmo_n, r_blk, w_blk_n;
  logic             r_parp, w_parp_n;
  logic             w_izq, w_der, w_salir, w_move;
  assign w_izq    = r_q[0] & ~r_qq[0];
  assign w_der    = r_q[1] & ~r_qq[1];
  assign w_salir  = r_q[2] & ~r_qq[2];
  assign w_move   = w_izq ^ w_der;
  assign w_cur_ok = (r_cur == 2'd3) ? 2'd0 : r_cur;
  // synchronizers reset high so a button held through reset never yields an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= 3'b111;
      r_qq    <= 3'b111;
      r_state <= IDLE;
      r_cur   <= 2'd0;
      r_tmo   <= '0;
      r_blk   <= '0;
      r_parp  <= 1'b0;
    end else begin
      r_q     <= {btn_salir, btn_der, btn_izq};
      r_qq    <= r_q;
      r_state <= w_state_n;
      r_cur   <= w_cur_n;
      r_tmo   <= w_tmo_n;
      r_blk   <= w_blk_n;
      r_parp  <= w_parp_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_cur_n   = 2'd0;
    w_tmo_n   = '0;
    w_blk_n   = '0;
    w_parp_n  = 1'b0;
    if (r_state == IDLE) begin
      w_state_n = sel_hora ? ED_HORA : sel_fecha ? ED_FECHA : sel_timer ? ED_TIMER : IDLE;
      w_parp_n  = (w_state_n != IDLE);
    end else if (w_salir || r_tmo == TMO_LAST) begin
      w_state_n = IDLE;
    end else begin
      w_tmo_n  = (w_izq | w_der) ? '0 : (&r_tmo) ? r_tmo : r_tmo + ONE;
      w_cur_n  = (w_izq & ~w_der) ? ((w_cur_ok == 2'd0) ? 2'd2 : w_cur_ok - 2'd1) :
                 (w_der & ~w_izq) ? ((w_cur_ok == 2'd2) ? 2'd0 : w_cur_ok + 2'd1) : w_cur_ok;
      w_blk_n  = (w_move || r_blk == BLK_LAST) ? '0 : r_blk + ONE;
      w_parp_n = w_move ? 1'b1 : (r_blk == BLK_LAST) ? ~r_parp : r_parp;
    end
  end
  assign dir_bin       = (r_state == IDLE) ? 2'b11 : r_cur;
  assign en_cont_hora  = (r_state == ED_HORA);
  assign en_cont_fecha = (r_state == ED_FECHA);
  assign en_cont_timer = (r_state == ED_TIMER);
  assign parpadeo      = r_parp;
  assign editando      = (r_state != IDLE);
endmodule
